// File: rtl/frog_sprite_engine_pkg.sv
// Shared VGA / sprite definitions for the frog sprite engine.
//   - visible area size, sprite size, hop geometry and timing
//   - colour constants (12-bit, [11:8]=blue, [7:4]=green, [3:0]=red)
//   - hop direction type and the sprite texel lookup
package frog_sprite_engine_pkg;

    localparam int H_VISIBLE       = 640;
    localparam int V_VISIBLE       = 480;
    localparam int SPRITE_SIZE     = 32;
    localparam int HOP_STEP        = 4;
    localparam int HOP_FRAMES      = 8;
    localparam int COOLDOWN_FRAMES = 2;
    localparam int START_X         = 304;
    localparam int START_Y         = 448;

    // Largest legal top-left coordinate keeps the whole sprite on screen.
    localparam int X_MAX    = H_VISIBLE - SPRITE_SIZE;
    localparam int Y_MAX    = V_VISIBLE - SPRITE_SIZE;
    localparam int HOP_DIST = HOP_STEP * HOP_FRAMES;

    localparam logic [11:0] COLOR_EYE   = 12'hfff;
    localparam logic [11:0] COLOR_BODY  = 12'h0f0;
    localparam logic [11:0] COLOR_BLACK = 12'h000;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Colour of a sprite texel given its local column/row (0..31).
    function automatic logic [11:0] sprite_texel(input logic [4:0] col,
                                                 input logic [4:0] row);
        logic eye_row;
        logic eye_col;
        eye_row = (row >= 5'd4) && (row <= 5'd7);
        eye_col = ((col >= 5'd6)  && (col <= 5'd9)) ||
                  ((col >= 5'd22) && (col <= 5'd25));
        return (eye_row && eye_col) ? COLOR_EYE : COLOR_BODY;
    endfunction

endpackage

// File: rtl/frog_sprite_engine_button_sync.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   i_btn        raw asynchronous push-button, active-high
//   o_rise       one-cycle pulse on each synchronized rising edge
module frog_sprite_engine_button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/frog_sprite_engine.sv
// Frog sprite engine: moves a 32x32 frog sprite in 32-px hops driven by four
// push-buttons, one hop step per video frame, and renders the sprite colour
// for the current scan coordinate with one cycle of latency.
// Ports:
//   clk, rst_n                      system clock, asynchronous active-low reset
//   io_frame_tick                   pulse at first cycle of vertical blanking
//   io_pixel_x/y, io_pixel_valid    current scan coordinate and visibility
//   io_btn_up/down/left/right       raw asynchronous buttons, active-high
//   io_rgb_color                    registered pixel colour
//   io_frog_x/y                     registered sprite top-left position
//   io_hopping                      high while in HOP state
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a frame tick with a pending, in-bounds direction
// HOP      | moving 4 px per frame tick, r_cnt frames remaining
// COOLDOWN | rest period after a hop, r_cnt frame ticks remaining
module frog_sprite_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_frame_tick,
    input  logic [10:0] io_pixel_x,
    input  logic [10:0] io_pixel_y,
    input  logic        io_pixel_valid,
    input  logic        io_btn_up,
    input  logic        io_btn_down,
    input  logic        io_btn_left,
    input  logic        io_btn_right,
    output logic [11:0] io_rgb_color,
    output logic [10:0] io_frog_x,
    output logic [10:0] io_frog_y,
    output logic        io_hopping
);

    import frog_sprite_engine_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOP      = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    localparam logic [10:0] C_START_X  = 11'(START_X);
    localparam logic [10:0] C_START_Y  = 11'(START_Y);
    localparam logic [10:0] C_X_MAX    = 11'(X_MAX);
    localparam logic [10:0] C_Y_MAX    = 11'(Y_MAX);
    localparam logic [10:0] C_HOP_DIST = 11'(HOP_DIST);
    localparam logic [10:0] C_STEP     = 11'(HOP_STEP);
    localparam logic [10:0] C_SIZE     = 11'(SPRITE_SIZE);
    localparam logic [3:0]  C_HOP_CNT  = 4'(HOP_FRAMES);
    localparam logic [3:0]  C_COOL_CNT = 4'(COOLDOWN_FRAMES);

    // Bit order of the button vectors: [0]=up [1]=down [2]=left [3]=right.
    logic [3:0]  w_btn_raw;
    logic [3:0]  w_rise;

    state_e      r_state;
    logic [3:0]  r_cnt;
    dir_e        r_dir;
    logic [3:0]  r_pend;
    logic [10:0] r_frog_x;
    logic [10:0] r_frog_y;
    logic        r_hopping;
    logic [11:0] r_rgb;

    dir_e        w_sel_dir;
    logic        w_in_bounds;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_hit;

    assign w_btn_raw = {io_btn_right, io_btn_left, io_btn_down, io_btn_up};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        frog_sprite_engine_button_sync u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (w_btn_raw[g]),
            .o_rise (w_rise[g])
        );
    end

    // Highest-priority pending direction and whether a full hop fits.
    always_comb begin
        w_sel_dir = DIR_RIGHT;
        if (r_pend[0])      w_sel_dir = DIR_UP;
        else if (r_pend[1]) w_sel_dir = DIR_DOWN;
        else if (r_pend[2]) w_sel_dir = DIR_LEFT;

        w_in_bounds = 1'b0;
        case (w_sel_dir)
            DIR_UP:    w_in_bounds = (r_frog_y >= C_HOP_DIST);
            DIR_DOWN:  w_in_bounds = (r_frog_y <= C_Y_MAX - C_HOP_DIST);
            DIR_LEFT:  w_in_bounds = (r_frog_x >= C_HOP_DIST);
            DIR_RIGHT: w_in_bounds = (r_frog_x <= C_X_MAX - C_HOP_DIST);
            default:   w_in_bounds = 1'b0;
        endcase
    end

    // Decisions on a frame tick use r_pend as it stood before this cycle, so an
    // edge arriving together with the tick is merged into the new pending set
    // and waits for the following tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_dir     <= DIR_UP;
            r_pend    <= 4'd0;
            r_frog_x  <= C_START_X;
            r_frog_y  <= C_START_Y;
            r_hopping <= 1'b0;
        end else begin
            r_pend <= r_pend | w_rise;
            if (io_frame_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (|r_pend) begin
                            // Hop taken or discarded: every queued direction goes.
                            r_pend <= w_rise;
                            if (w_in_bounds) begin
                                r_state   <= ST_HOP;
                                r_dir     <= w_sel_dir;
                                r_cnt     <= C_HOP_CNT;
                                r_hopping <= 1'b1;
                            end
                        end
                    end
                    ST_HOP: begin
                        case (r_dir)
                            DIR_UP:    r_frog_y <= r_frog_y - C_STEP;
                            DIR_DOWN:  r_frog_y <= r_frog_y + C_STEP;
                            DIR_LEFT:  r_frog_x <= r_frog_x - C_STEP;
                            DIR_RIGHT: r_frog_x <= r_frog_x + C_STEP;
                            default:   r_frog_x <= r_frog_x;
                        endcase
                        if (r_cnt == 4'd1) begin
                            r_state   <= ST_COOLDOWN;
                            r_cnt     <= C_COOL_CNT;
                            r_hopping <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (r_cnt <= 4'd1) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= 4'd0;
                        r_hopping <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Unsigned offsets; the explicit >= guards stop underflow from wrapping
    // into a false hit left of / above the sprite.
    assign w_dx  = io_pixel_x - r_frog_x;
    assign w_dy  = io_pixel_y - r_frog_y;
    assign w_hit = io_pixel_valid &&
                   (io_pixel_x >= r_frog_x) && (w_dx < C_SIZE) &&
                   (io_pixel_y >= r_frog_y) && (w_dy < C_SIZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= COLOR_BLACK;
        end else begin
            r_rgb <= w_hit ? sprite_texel(w_dx[4:0], w_dy[4:0]) : COLOR_BLACK;
        end
    end

    assign io_rgb_color = r_rgb;
    assign io_frog_x    = r_frog_x;
    assign io_frog_y    = r_frog_y;
    assign io_hopping   = r_hopping;

endmodule
